// File: rtl/reg_bus_arbiter_pkg.sv
// Shared types and constants for the GPIO/ID register-bus arbiter.
package reg_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        CAPT   = 2'd2,
        RESP   = 2'd3
    } state_e;

    // Register word addresses inside the GPIO/ID block.
    localparam logic [2:0] CNAME    = 3'd0;
    localparam logic [2:0] CVERSION = 3'd1;
    localparam logic [2:0] TRISTATE = 3'd2;
    localparam logic [2:0] PINSTATE = 3'd3;
    localparam logic [2:0] INTMASK  = 3'd4;
    localparam logic [2:0] DATAREG  = 3'd5;
    localparam logic [2:0] SCRATCH  = 3'd6;

    // Bit n set means word address n accepts that kind of access.
    localparam logic [7:0] WR_MASK_DEFAULT = 8'b0111_0100;
    localparam logic [7:0] RD_MASK_DEFAULT = 8'b0111_1111;

    // An access is rejected when its direction is not permitted at that address.
    function automatic logic access_error(input logic       we,
                                          input logic [2:0] addr,
                                          input logic [7:0] wr_mask,
                                          input logic [7:0] rd_mask);
        logic err;
        if (we) begin
            err = ~wr_mask[addr];
        end else begin
            err = ~rd_mask[addr];
        end
        return err;
    endfunction

endpackage

// File: rtl/reg_bus_arbiter_if.sv
// One requester channel: req/gnt request side plus rvalid/rready response side.
interface reg_bus_if;
    logic        req;
    logic        we;
    logic [2:0]  addr;
    logic [3:0]  wben;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic        rerr;

    modport master (
        output req, we, addr, wben, wdata, rready,
        input  gnt, rvalid, rdata, rerr
    );

    modport slave (
        input  req, we, addr, wben, wdata, rready,
        output gnt, rvalid, rdata, rerr
    );
endinterface

// File: rtl/reg_bus_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; a tie goes to the master that did not win last.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    output logic [1:0] grant_o
);

    logic last_q;
    logic last_d;

    // Pick the winner and decide whether the fairness pointer moves.
    always_comb begin
        grant_o = 2'b00;
        last_d  = last_q;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
        if (upd_i && (grant_o != 2'b00)) begin
            last_d = grant_o[1];
        end else begin
            last_d = last_q;
        end
    end

    // Last winner starts at master 1 so master 0 takes the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Shares the single-ported GPIO/ID register block between the core and debug ports.
module reg_bus_arbiter
    import reg_bus_pkg::*;
#(
    parameter logic [7:0] WR_MASK = WR_MASK_DEFAULT,
    parameter logic [7:0] RD_MASK = RD_MASK_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    reg_bus_if.slave    m0,
    reg_bus_if.slave    m1,
    output logic [2:0]  reg_addr,
    output logic        reg_r_wn,
    output logic [3:0]  reg_wben,
    output logic [31:0] reg_wdata,
    input  logic [31:0] reg_rdata
);

    state_e      state_q, state_d;
    logic        mst_q, mst_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic [31:0] rsp_q, rsp_d;
    logic [2:0]  reg_addr_q, reg_addr_d;
    logic        reg_r_wn_q, reg_r_wn_d;
    logic [3:0]  reg_wben_q, reg_wben_d;
    logic [31:0] reg_wdata_q, reg_wdata_d;

    logic [1:0]  grant_s;
    logic [1:0]  gnt_s;
    logic        sel_we_s;
    logic [2:0]  sel_addr_s;
    logic [3:0]  sel_wben_s;
    logic [31:0] sel_wdata_s;
    logic        sel_err_s;
    logic        rready_s;
    logic        resp_s;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req_i   ({m1.req, m0.req}),
        .upd_i   (state_q == IDLE),
        .grant_o (grant_s)
    );

    // Route the winning master's request fields and classify the access.
    always_comb begin
        if (grant_s[1]) begin
            sel_we_s    = m1.we;
            sel_addr_s  = m1.addr;
            sel_wben_s  = m1.wben;
            sel_wdata_s = m1.wdata;
        end else begin
            sel_we_s    = m0.we;
            sel_addr_s  = m0.addr;
            sel_wben_s  = m0.wben;
            sel_wdata_s = m0.wdata;
        end
        sel_err_s = access_error(sel_we_s, sel_addr_s, WR_MASK, RD_MASK);
        rready_s  = mst_q ? m1.rready : m0.rready;
    end

    // Sequencer: grant in IDLE, drive the port in ACCESS, capture in CAPT, respond in RESP.
    always_comb begin
        state_d     = state_q;
        mst_d       = mst_q;
        we_d        = we_q;
        err_d       = err_q;
        rsp_d       = rsp_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_r_wn_d  = 1'b1;
        reg_wben_d  = 4'b0000;
        gnt_s       = 2'b00;
        case (state_q)
            IDLE: begin
                if (grant_s != 2'b00) begin
                    gnt_s      = grant_s;
                    mst_d      = grant_s[1];
                    we_d       = sel_we_s;
                    err_d      = sel_err_s;
                    reg_addr_d = sel_addr_s;
                    state_d    = ACCESS;
                    // Only a permitted write ever reaches the register block as a write.
                    if (sel_we_s && !sel_err_s) begin
                        reg_r_wn_d  = 1'b0;
                        reg_wben_d  = sel_wben_s;
                        reg_wdata_d = sel_wdata_s;
                    end else begin
                        reg_r_wn_d  = 1'b1;
                        reg_wben_d  = 4'b0000;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                state_d = CAPT;
            end
            CAPT: begin
                // Read data arrives one cycle after the read cycle.
                if (!we_q && !err_q) begin
                    rsp_d = reg_rdata;
                end else begin
                    rsp_d = 32'h0000_0000;
                end
                state_d = RESP;
            end
            RESP: begin
                if (rready_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, transaction latch and register-port outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mst_q       <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            rsp_q       <= 32'h0000_0000;
            reg_addr_q  <= 3'd0;
            reg_r_wn_q  <= 1'b1;
            reg_wben_q  <= 4'b0000;
            reg_wdata_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            mst_q       <= mst_d;
            we_q        <= we_d;
            err_q       <= err_d;
            rsp_q       <= rsp_d;
            reg_addr_q  <= reg_addr_d;
            reg_r_wn_q  <= reg_r_wn_d;
            reg_wben_q  <= reg_wben_d;
            reg_wdata_q <= reg_wdata_d;
        end
    end

    assign resp_s    = (state_q == RESP);
    assign reg_addr  = reg_addr_q;
    assign reg_r_wn  = reg_r_wn_q;
    assign reg_wben  = reg_wben_q;
    assign reg_wdata = reg_wdata_q;

    assign m0.gnt    = gnt_s[0];
    assign m1.gnt    = gnt_s[1];
    assign m0.rvalid = resp_s & ~mst_q;
    assign m1.rvalid = resp_s & mst_q;
    assign m0.rerr   = resp_s & ~mst_q & err_q;
    assign m1.rerr   = resp_s & mst_q & err_q;
    assign m0.rdata  = (resp_s && !mst_q) ? rsp_q : 32'h0000_0000;
    assign m1.rdata  = (resp_s && mst_q) ? rsp_q : 32'h0000_0000;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter: transaction-level reference model plus directed and random traffic.
module tb_reg_bus_arbiter;
    import reg_bus_pkg::*;

    localparam logic [7:0] TB_WR = 8'b0111_0100;
    localparam logic [7:0] TB_RD = 8'b0111_1111;

    typedef struct packed {
        logic        we;
        logic [2:0]  addr;
        logic [3:0]  wben;
        logic [31:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    reg_bus_if m0_if ();
    reg_bus_if m1_if ();

    logic [2:0]  reg_addr;
    logic        reg_r_wn;
    logic [3:0]  reg_wben;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata = 32'h0;

    reg_bus_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .m0        (m0_if),
        .m1        (m1_if),
        .reg_addr  (reg_addr),
        .reg_r_wn  (reg_r_wn),
        .reg_wben  (reg_wben),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata)
    );

    // Stimulus side
    txn_t       cur [2];
    logic [1:0] req_v = 2'b00;
    logic [1:0] rready_v = 2'b11;
    txn_t       q0[$];
    txn_t       q1[$];
    bit         abort_en = 1'b0;
    bit         rr_rand = 1'b0;

    assign m0_if.req    = req_v[0];
    assign m0_if.we     = cur[0].we;
    assign m0_if.addr   = cur[0].addr;
    assign m0_if.wben   = cur[0].wben;
    assign m0_if.wdata  = cur[0].wdata;
    assign m0_if.rready = rready_v[0];
    assign m1_if.req    = req_v[1];
    assign m1_if.we     = cur[1].we;
    assign m1_if.addr   = cur[1].addr;
    assign m1_if.wben   = cur[1].wben;
    assign m1_if.wdata  = cur[1].wdata;
    assign m1_if.rready = rready_v[1];

    wire [1:0]  gnt_w    = {m1_if.gnt, m0_if.gnt};
    wire [1:0]  rvalid_w = {m1_if.rvalid, m0_if.rvalid};
    wire [1:0]  rerr_w   = {m1_if.rerr, m0_if.rerr};
    wire [31:0] rdata_w [2];
    assign rdata_w[0] = m0_if.rdata;
    assign rdata_w[1] = m1_if.rdata;

    // Register block stand-in: byte-enabled writes, one-cycle-latency reads.
    logic [31:0] blk [8] = '{32'h48524A44, 32'h1, 32'h0, 32'hA5, 32'h0, 32'h0, 32'h0, 32'hDEAD0007};
    always @(posedge clk) begin
        if (!reg_r_wn) begin
            for (int b = 0; b < 4; b++) begin
                if (reg_wben[b]) blk[reg_addr][b*8 +: 8] <= reg_wdata[b*8 +: 8];
            end
        end
        reg_rdata <= blk[reg_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model state: one outstanding transaction, counted in cycles since its grant.
    logic [31:0] mmem [8] = '{32'h48524A44, 32'h1, 32'h0, 32'hA5, 32'h0, 32'h0, 32'h0, 32'hDEAD0007};
    bit          busy = 1'b0;
    int          phase = 0;
    int          cur_m = 0;
    bit          cur_err, cur_wr;
    logic [3:0]  cur_wben;
    logic [31:0] cur_wdata, cur_data;
    logic [2:0]  exp_addr = 3'd0;
    int          last_g = 1;

    // Observations for directed checks
    bit          gnt_seen [2];
    int          gnt_cyc [2];
    int          gcnt [2];
    int          rv_cyc [2];
    int          hs_cyc [2];
    bit          prev_rv [2];
    logic [31:0] last_data [2];
    logic        last_err [2];
    int          wr_cyc = 0;
    int          wr_count = 0;
    int          grant_log[$];

    // Compare DUT against the model every cycle, then advance the model.
    always @(negedge clk) begin
        int   w;
        bit   acc, ev;
        txn_t t;
        logic [7:0] wrm, rdm;
        wrm = TB_WR;
        rdm = TB_RD;
        if (!reset) begin
            chk("rst_gnt", {30'd0, gnt_w}, 32'd0);
            chk("rst_rvalid", {30'd0, rvalid_w}, 32'd0);
            chk("rst_rerr", {30'd0, rerr_w}, 32'd0);
            chk("rst_rdata0", rdata_w[0], 32'd0);
            chk("rst_rdata1", rdata_w[1], 32'd0);
            chk("rst_r_wn", {31'd0, reg_r_wn}, 32'd1);
            chk("rst_wben", {28'd0, reg_wben}, 32'd0);
            chk("rst_addr", {29'd0, reg_addr}, 32'd0);
            chk("rst_wdata", reg_wdata, 32'd0);
            busy = 1'b0;
            last_g = 1;
            exp_addr = 3'd0;
            gnt_seen[0] = 1'b0;
            gnt_seen[1] = 1'b0;
            prev_rv[0] = 1'b0;
            prev_rv[1] = 1'b0;
        end else begin
            w = -1;
            if (req_v == 2'b01) w = 0;
            else if (req_v == 2'b10) w = 1;
            else if (req_v == 2'b11) w = (last_g == 1) ? 0 : 1;
            acc = busy && (phase == 1) && cur_wr;
            chk("reg_r_wn", {31'd0, reg_r_wn}, {31'd0, !acc});
            chk("reg_wben", {28'd0, reg_wben}, acc ? {28'd0, cur_wben} : 32'd0);
            chk("reg_addr", {29'd0, reg_addr}, {29'd0, exp_addr});
            if (acc) chk("reg_wdata", reg_wdata, cur_wdata);
            for (int m = 0; m < 2; m++) begin
                ev = busy && (phase >= 3) && (cur_m == m);
                chk($sformatf("gnt%0d", m), {31'd0, gnt_w[m]}, {31'd0, (!busy && w == m)});
                chk($sformatf("rvalid%0d", m), {31'd0, rvalid_w[m]}, {31'd0, ev});
                chk($sformatf("rdata%0d", m), rdata_w[m], ev ? cur_data : 32'd0);
                chk($sformatf("rerr%0d", m), {31'd0, rerr_w[m]}, {31'd0, ev && cur_err});
                gnt_seen[m] = gnt_w[m];
                if (gnt_w[m]) begin
                    gnt_cyc[m] = cyc;
                    gcnt[m]++;
                    grant_log.push_back(m);
                end
                if (rvalid_w[m] && !prev_rv[m]) rv_cyc[m] = cyc;
                if (rvalid_w[m] && rready_v[m]) begin
                    hs_cyc[m] = cyc;
                    last_data[m] = rdata_w[m];
                    last_err[m] = rerr_w[m];
                end
                prev_rv[m] = rvalid_w[m] && !rready_v[m];
            end
            if (!reg_r_wn) begin
                wr_cyc = cyc;
                wr_count++;
            end
            if (!busy && w >= 0) begin
                t         = cur[w];
                busy      = 1'b1;
                phase     = 1;
                cur_m     = w;
                cur_err   = t.we ? !wrm[t.addr] : !rdm[t.addr];
                cur_wr    = t.we && !cur_err;
                cur_wben  = t.wben;
                cur_wdata = t.wdata;
                exp_addr  = t.addr;
                if (cur_wr) begin
                    for (int b = 0; b < 4; b++) begin
                        if (t.wben[b]) mmem[t.addr][b*8 +: 8] = t.wdata[b*8 +: 8];
                    end
                end
                cur_data = (!t.we && !cur_err) ? mmem[t.addr] : 32'd0;
                last_g   = w;
            end else if (busy) begin
                if (phase >= 3) begin
                    if (rready_v[cur_m]) busy = 1'b0;
                end else begin
                    phase++;
                end
            end
        end
    end

    // Request driver: hold each request until granted, then take the next queued one.
    always @(posedge clk) begin
        #1;
        for (int m = 0; m < 2; m++) begin
            if (!reset) begin
                req_v[m] = 1'b0;
            end else begin
                if (req_v[m] && gnt_seen[m]) req_v[m] = 1'b0;
                else if (req_v[m] && abort_en && $urandom_range(0, 7) == 0) req_v[m] = 1'b0;
                if (!req_v[m]) begin
                    if (m == 0 && q0.size() > 0) begin
                        cur[0] = q0.pop_front();
                        req_v[0] = 1'b1;
                    end else if (m == 1 && q1.size() > 0) begin
                        cur[1] = q1.pop_front();
                        req_v[1] = 1'b1;
                    end
                end
            end
            if (rr_rand) rready_v[m] = 1'($urandom_range(0, 1));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic txn_t mk(input logic we, input logic [2:0] a, input logic [3:0] be, input logic [31:0] d);
        txn_t t;
        t.we = we; t.addr = a; t.wben = be; t.wdata = d;
        return t;
    endfunction

    task automatic drain(input string nm, input int budget);
        int n = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && req_v == 2'b00 && !busy) && n < budget) begin
            step();
            n++;
        end
        chk({nm, "_drain"}, {31'd0, (n < budget)}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int wc;
        cur[0] = '0;
        cur[1] = '0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        step();

        // Both masters read CNAME continuously: m0 first, then strict alternation.
        grant_log.delete();
        for (int i = 0; i < 3; i++) begin
            q0.push_back(mk(1'b0, CNAME, 4'h0, 32'h0));
            q1.push_back(mk(1'b0, CNAME, 4'h0, 32'h0));
        end
        drain("alt", 100);
        chk("alt_count", grant_log.size(), 32'd6);
        for (int i = 0; i < grant_log.size() && i < 6; i++) chk("alt_order", grant_log[i], i % 2);
        chk("alt_data0", last_data[0], 32'h48524A44);
        chk("alt_data1", last_data[1], 32'h48524A44);

        // Scratch write then read back; latency pins.
        q0.push_back(mk(1'b1, SCRATCH, 4'hF, 32'hDEADBEEF));
        drain("wr6", 40);
        chk("wr_lat", wr_cyc - gnt_cyc[0], 32'd1);
        q0.push_back(mk(1'b0, SCRATCH, 4'h0, 32'h0));
        drain("rd6", 40);
        chk("rd_lat", rv_cyc[0] - gnt_cyc[0], 32'd3);
        chk("rd6_data", last_data[0], 32'hDEADBEEF);
        chk("rd6_err", {31'd0, last_err[0]}, 32'd0);

        // Write to read-only CVERSION is blocked.
        wc = wr_count;
        q1.push_back(mk(1'b1, CVERSION, 4'hF, 32'hFFFF_FFFF));
        drain("ro_wr", 40);
        chk("ro_nowrite", wr_count - wc, 32'd0);
        chk("ro_err", {31'd0, last_err[1]}, 32'd1);
        chk("ro_data", last_data[1], 32'd0);
        q1.push_back(mk(1'b0, CVERSION, 4'h0, 32'h0));
        drain("ro_rd", 40);
        chk("ro_rd_data", last_data[1], 32'h1);

        // Unmapped read, partial write, no-op write.
        q0.push_back(mk(1'b0, 3'd7, 4'h0, 32'h0));
        drain("um", 40);
        chk("um_err", {31'd0, last_err[0]}, 32'd1);
        chk("um_data", last_data[0], 32'd0);
        q0.push_back(mk(1'b1, DATAREG, 4'b0001, 32'h0000_12AB));
        q0.push_back(mk(1'b0, DATAREG, 4'h0, 32'h0));
        drain("part", 60);
        chk("part_data", last_data[0], 32'h0000_00AB);
        q0.push_back(mk(1'b1, SCRATCH, 4'h0, 32'h1234_5678));
        drain("noop", 40);
        chk("noop_err", {31'd0, last_err[0]}, 32'd0);
        q0.push_back(mk(1'b0, SCRATCH, 4'h0, 32'h0));
        drain("noop_rd", 40);
        chk("noop_rd", last_data[0], 32'hDEADBEEF);

        // Response stall: m0 rready low, m1 waits without a grant.
        rready_v[0] = 1'b0;
        q0.push_back(mk(1'b0, PINSTATE, 4'h0, 32'h0));
        n = 0;
        while (!rvalid_w[0] && n < 20) begin step(); n++; end
        chk("stall_rv_wait", {31'd0, rvalid_w[0]}, 32'd1);
        q1.push_back(mk(1'b0, CNAME, 4'h0, 32'h0));
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_rvalid", {31'd0, rvalid_w[0]}, 32'd1);
            chk("stall_rdata", rdata_w[0], 32'h0000_00A5);
            chk("stall_gnt1", {31'd0, gnt_w[1]}, 32'd0);
        end
        rready_v[0] = 1'b1;
        drain("stall", 40);
        chk("stall_gnt_after", gnt_cyc[1] - hs_cyc[0], 32'd1);

        // Reset during CAPT of an m1 read.
        wc = gcnt[1];
        q1.push_back(mk(1'b0, DATAREG, 4'h0, 32'h0));
        n = 0;
        while (gcnt[1] == wc && n < 20) begin step(); n++; end
        chk("rst_gnt_wait", {31'd0, (gcnt[1] != wc)}, 32'd1);
        step();
        reset = 1'b0;
        #1;
        chk("mid_rst_addr", {29'd0, reg_addr}, 32'd0);
        chk("mid_rst_rvalid", {30'd0, rvalid_w}, 32'd0);
        chk("mid_rst_r_wn", {31'd0, reg_r_wn}, 32'd1);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        step();
        grant_log.delete();
        q0.push_back(mk(1'b0, CNAME, 4'h0, 32'h0));
        q1.push_back(mk(1'b0, CNAME, 4'h0, 32'h0));
        drain("post_rst", 60);
        chk("post_rst_first", grant_log.size() > 0 ? grant_log[0] : 9, 32'd0);
        chk("post_rst_data", last_data[0], 32'h48524A44);

        // Random traffic with withdrawn requests and random rready.
        abort_en = 1'b1;
        rr_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (q0.size() < 3 && $urandom_range(0, 3) == 0)
                q0.push_back(mk(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), $urandom));
            if (q1.size() < 3 && $urandom_range(0, 3) == 0)
                q1.push_back(mk(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), $urandom));
            step();
        end
        abort_en = 1'b0;
        rr_rand = 1'b0;
        rready_v = 2'b11;
        drain("rand", 300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_bus_arbiter.md
Name: reg_bus_arbiter

Overview:
Shares the single-ported GPIO/ID register block between two requesters: master 0 (core load/store port) and master 1 (debug port). Each master uses a req/gnt request channel and an rvalid/rready response channel. The block round-robin arbitrates, sequences one register access at a time onto the register port, and captures the one-cycle-latency read data. It also blocks writes to read-only or unmapped addresses and flags them as errors.

Parameters:
WR_MASK, 8'b0111_0100, bit n set = address n writable (2 tristate, 4 int mask, 5 datareg, 6 scratch)
RD_MASK, 8'b0111_1111, bit n set = address n readable (7 unmapped)

Ports:
clk  in  1  master clock
reset  in  1  asynchronous, active-low reset (0 = reset)
mX_req  in  1  request valid (X = 0, 1); held with its fields until mX_gnt
mX_we  in  1  1 = write, 0 = read
mX_addr  in  3  word address [4:2]
mX_wben  in  4  byte enables (writes only)
mX_wdata  in  32  write data
mX_gnt  out  1  single-cycle accept pulse
mX_rvalid  out  1  response valid, held until mX_rready
mX_rready  in  1  response accept
mX_rdata  out  32  read data (0 for writes and errors)
mX_rerr  out  1  access rejected
reg_addr  out  3  to register block
reg_r_wn  out  1  1 = read, 0 = write
reg_wben  out  4  to register block
reg_wdata  out  32  to register block
reg_rdata  in  32  from register block; valid one cycle after the read cycle

Behaviour:
- Reset state: state IDLE; all gnt, rvalid, and rerr outputs 0; rdata 0; reg_r_wn=1; reg_wben=0; reg_addr=0; reg_wdata=0; last_grant=1, so m0 wins the first tie.
- FSM: IDLE -> ACCESS -> CAPT -> RESP -> IDLE.
- IDLE:
  - If any req is high, grant one. The winner is the sole requester, or on a tie the master not equal to last_grant.
  - mX_gnt pulses combinationally in this cycle.
  - Latch we/addr/wben/wdata and the master id; update last_grant; go to ACCESS.
- Error check in IDLE: error = (we & !WR_MASK[addr]) | (!we & !RD_MASK[addr]). The result is latched.
- ACCESS (1 cycle), registered port outputs:
  - Non-error write: reg_r_wn=0, reg_wben and reg_wdata from the latch.
  - Read: reg_r_wn=1, wben=0.
  - Error: reg_r_wn=1, wben=0, so nothing is written.
  - reg_addr = latched addr.
- CAPT (1 cycle):
  - reg_r_wn=1, wben=0, reg_addr held.
  - Latch rsp_data = (read & !error) ? reg_rdata : 0.
- RESP: assert mX_rvalid, mX_rdata, and mX_rerr for the latched master only; hold until mX_rready. Go to IDLE on the cycle rvalid & rready.
- Latency: gnt in cycle 0; earliest rvalid in cycle 3. Throughput is one access per 4 cycles when rready is held high.
- Outside ACCESS: reg_r_wn=1 and reg_wben=0 always. Idle read cycles are harmless. reg_addr holds its last value.
- A req dropped before gnt means no access. A req raised during ACCESS/CAPT/RESP waits, with no gnt.
- A write with wben=0 is a legal no-op write; the response is returned with rerr=0.
- rready asserted with rvalid low is ignored.
- Asynchronous reset mid-transaction: immediately return to reset values. A pending response is discarded and a write in ACCESS may be cut short.

Decomposition:
- Package reg_bus_pkg holds:
  - state enum (IDLE, ACCESS, CAPT, RESP);
  - register address constants (CNAME=0, CVERSION=1, TRISTATE=2, PINSTATE=3, INTMASK=4, DATAREG=5, SCRATCH=6);
  - default WR_MASK/RD_MASK.
- Sub-module rr_arb2: 2-way round-robin arbiter (req[1:0], last_grant, grant one-hot, update enable).

Test Plan:
- m0 write addr 6, wben 4'hF, wdata 32'hDEADBEEF; then m0 reads addr 6:
  - write: gnt at cycle 0, reg_r_wn=0 in cycle 1;
  - read: rvalid at cycle 3 with rdata=32'hDEADBEEF, rerr=0.
- m0 and m1 both read addr 0, held high together, rready=1:
  - m0 is granted first, then m1;
  - both return rdata=32'h48524A44, and grants alternate 0,1,0,1 for continuous requests.
- m1 write addr 1 (read-only) with wben 4'hF: reg_r_wn stays 1 throughout; m1_rerr=1, rdata=0; a follow-up read of addr 1 returns 32'h00000001.
- m0 read addr 7: rerr=1, rdata=0. m0 write addr 5, wben 4'b0001, wdata 32'h0000_12AB, then read addr 5: returns 32'h0000_00AB on top of prior 0.
- m0 read with rready held low 5 cycles: rvalid and rdata stable; m1_req meanwhile gets no gnt until the cycle after the m0 handshake.
- reset asserted during CAPT of an m1 read: all outputs reach reset values immediately with no rvalid. After release, an m0 read of addr 0 completes normally and m0 wins the tie first.
